// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit frame controller: default geometry and counter widths.
package i2s_pkg;

    localparam int DEFAULT_RESOLUTION = 24;
    localparam int DEFAULT_SLOT_BITS  = 32;
    localparam int DEFAULT_SCLK_DIV   = 4;

    // Width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int BIT_CNT_W = cnt_width(2 * DEFAULT_SLOT_BITS);
    localparam int DIV_CNT_W = cnt_width(DEFAULT_SCLK_DIV);

endpackage

// File: rtl/i2s_clk_gen.sv
// SCLK/LRCK generator: CLK divider, per-frame bit counter and the frame-start strobe.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV  = DEFAULT_SCLK_DIV,
    parameter int SLOT_BITS = DEFAULT_SLOT_BITS
) (
    input  logic CLK,
    input  logic RST,
    input  logic en_i,
    output logic sclk_o,
    output logic lrck_o,
    output logic fs_o
);

    localparam int DIV_W = cnt_width(SCLK_DIV);
    localparam int BIT_W = cnt_width(2 * SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_BITS);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BIT_W-1:0] bit_inc;
    logic             sclk_q, sclk_d;
    logic             lrck_q, lrck_d;
    logic             started_q, started_d;
    logic             wrap;

    assign bit_inc = bit_cnt_q + 1'b1;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        lrck_d    = lrck_q;
        started_d = started_q;
        wrap      = 1'b0;
        if (!en_i) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
            sclk_d    = 1'b0;
            lrck_d    = 1'b0;
            started_d = 1'b0;
        end else begin
            started_d = 1'b1;
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                sclk_d    = !sclk_q;
                // Bit counter and LRCK move only on SCLK rising toggles, keeping LRCK stable at SCLK falls.
                if (!sclk_q) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        lrck_d    = 1'b0;
                        wrap      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_inc;
                        if (bit_inc == SLOT_START) lrck_d = 1'b1;
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            started_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            lrck_q    <= lrck_d;
            started_q <= started_d;
        end
    end

    assign sclk_o = sclk_q;
    assign lrck_o = lrck_q;
    assign fs_o   = en_i && (!started_q || wrap);

endmodule

// File: rtl/i2s_tx_frame_ctrl.sv
// Master-mode I2S transmit frame controller: single-entry sample buffer, frame-aligned outputs, underrun pulse.
// Build option I2S_UNDERRUN_MUTE_EN: an underrun frame outputs zeros instead of repeating the last pair.
module i2s_tx_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int RESOLUTION = DEFAULT_RESOLUTION,
    parameter int SCLK_DIV   = DEFAULT_SCLK_DIV,
    parameter int SLOT_BITS  = DEFAULT_SLOT_BITS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [RESOLUTION-1:0] sample_L_in,
    input  logic [RESOLUTION-1:0] sample_R_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  SCLK,
    output logic                  LRCK,
    output logic [RESOLUTION-1:0] data_L_out,
    output logic [RESOLUTION-1:0] data_R_out,
    output logic                  underrun
);

    logic                  fs;
    logic                  xfer;
    logic                  pending_q, pending_d;
    logic [RESOLUTION-1:0] pend_l_q, pend_l_d;
    logic [RESOLUTION-1:0] pend_r_q, pend_r_d;
    logic [RESOLUTION-1:0] data_l_q, data_l_d;
    logic [RESOLUTION-1:0] data_r_q, data_r_d;
    logic                  underrun_q, underrun_d;

    i2s_clk_gen #(
        .SCLK_DIV (SCLK_DIV),
        .SLOT_BITS(SLOT_BITS)
    ) u_clk_gen (
        .CLK   (CLK),
        .RST   (RST),
        .en_i  (EN),
        .sclk_o(SCLK),
        .lrck_o(LRCK),
        .fs_o  (fs)
    );

    assign sample_ready = !pending_q;
    assign xfer         = sample_valid && !pending_q;

    always_comb begin
        pending_d  = pending_q;
        pend_l_d   = pend_l_q;
        pend_r_d   = pend_r_q;
        data_l_d   = data_l_q;
        data_r_d   = data_r_q;
        underrun_d = 1'b0;
        if (fs) begin
            if (pending_q) begin
                data_l_d  = pend_l_q;
                data_r_d  = pend_r_q;
                pending_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
`ifdef I2S_UNDERRUN_MUTE_EN
                data_l_d = '0;
                data_r_d = '0;
`else
                data_l_d = data_l_q;
                data_r_d = data_r_q;
`endif
            end
        end
        // A transfer only happens with the buffer empty, so it never collides with an FS drain.
        if (xfer) begin
            pending_d = 1'b1;
            pend_l_d  = sample_L_in;
            pend_r_d  = sample_R_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the pending pair is reset too; it is a couple of registers, not a RAM, and a known value aids debug.
            pending_q  <= 1'b0;
            pend_l_q   <= '0;
            pend_r_q   <= '0;
            data_l_q   <= '0;
            data_r_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            pend_l_q   <= pend_l_d;
            pend_r_q   <= pend_r_d;
            data_l_q   <= data_l_d;
            data_r_q   <= data_r_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_L_out = data_l_q;
    assign data_R_out = data_r_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_tx_frame_ctrl.sv
// Directed bench for i2s_tx_frame_ctrl at SCLK_DIV=2, SLOT_BITS=32, RESOLUTION=24 (256-CLK frames).
module tb_i2s_tx_frame_ctrl;

`ifdef I2S_UNDERRUN_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [23:0] sample_L_in;
    logic [23:0] sample_R_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        SCLK;
    logic        LRCK;
    logic [23:0] data_L_out;
    logic [23:0] data_R_out;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;

    int n_cyc, n_xfer, n_lrck_hi, n_sclk_hi, n_sclk_rise, n_underrun, n_ur_rise;
    int n_dchg, n_bad_chg, n_fall_chg, last_rise, iv_min, iv_max;
    logic        p_sclk, p_lrck, p_ur;
    logic [23:0] p_dl, p_dr;

    i2s_tx_frame_ctrl #(
        .RESOLUTION(24),
        .SCLK_DIV  (2),
        .SLOT_BITS (32)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .sample_L_in (sample_L_in),
        .sample_R_in (sample_R_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .SCLK        (SCLK),
        .LRCK        (LRCK),
        .data_L_out  (data_L_out),
        .data_R_out  (data_R_out),
        .underrun    (underrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        p_sclk = SCLK;
        p_lrck = LRCK;
        p_ur   = underrun;
        p_dl   = data_L_out;
        p_dr   = data_R_out;
    endtask

    task automatic clr_stats();
        n_cyc = 0; n_xfer = 0; n_lrck_hi = 0; n_sclk_hi = 0; n_sclk_rise = 0;
        n_underrun = 0; n_ur_rise = 0; n_dchg = 0; n_bad_chg = 0; n_fall_chg = 0;
        last_rise = -1; iv_min = 1000000; iv_max = 0;
    endtask

    // One CLK edge; outputs are observed 1 ns after it and folded into the running statistics.
    task automatic tick();
        logic xf;
        logic dchg;
        xf = sample_valid && sample_ready;
        @(posedge CLK);
        #1;
        n_cyc++;
        if (xf) n_xfer++;
        if (LRCK) n_lrck_hi++;
        if (SCLK) n_sclk_hi++;
        if (underrun) n_underrun++;
        if (underrun && !p_ur) n_ur_rise++;
        if (SCLK && !p_sclk) begin
            n_sclk_rise++;
            if (last_rise >= 0) begin
                if (n_cyc - last_rise < iv_min) iv_min = n_cyc - last_rise;
                if (n_cyc - last_rise > iv_max) iv_max = n_cyc - last_rise;
            end
            last_rise = n_cyc;
        end
        dchg = (data_L_out !== p_dl) || (data_R_out !== p_dr);
        if (dchg) n_dchg++;
        if (dchg && !(p_lrck && !LRCK)) n_bad_chg++;
        if (dchg && p_sclk && !SCLK) n_fall_chg++;
        snap();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; sample_valid = 1'b0;
        sample_L_in = '0; sample_R_in = '0;
        clr_stats();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_sclk", SCLK, 0);
        check("rst_lrck", LRCK, 0);
        check("rst_data_l", data_L_out, 0);
        check("rst_data_r", data_R_out, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", sample_ready, 1);

        // Test 1: first enable, pair held valid.
        @(negedge CLK);
        RST = 1'b0; EN = 1'b1; sample_valid = 1'b1;
        sample_L_in = 24'h123456; sample_R_in = 24'hABCDEF;
        snap(); clr_stats();
        tick();
        check("t1_init_underrun", underrun, 1);
        check("t1_init_data_l", data_L_out, 0);
        check("t1_init_ready", sample_ready, 0);
        clr_stats();
        run(253);
        check("t1_fs_data_l", data_L_out, 24'h123456);
        check("t1_fs_data_r", data_R_out, 24'hABCDEF);
        check("t1_fs_lrck", LRCK, 0);
        check("t1_no_underrun", n_underrun, 0);
        check("t1_sclk_iv_min", iv_min, 4);
        check("t1_sclk_iv_max", iv_max, 4);
        check("t1_lrck_hi_first", n_lrck_hi, 128);
        clr_stats();
        run(256);
        check("t1_lrck_hi", n_lrck_hi, 128);
        check("t1_sclk_rises", n_sclk_rise, 64);
        check("t1_underrun2", n_underrun, 0);
        check("t1_xfer", n_xfer, 1);

        // Test 2: one incrementing pair per frame.
        clr_stats();
        for (int k = 1; k <= 3; k++) begin
            sample_L_in = 24'h000100 + 24'(k);
            sample_R_in = 24'h00F000 + 24'(k);
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            run(255);
            check("t2_data_l", data_L_out, 24'h000100 + 24'(k));
            check("t2_data_r", data_R_out, 24'h00F000 + 24'(k));
        end
        check("t2_underrun", n_underrun, 0);
        check("t2_xfer", n_xfer, 3);
        check("t2_dchg", n_dchg, 3);
        check("t2_chg_off_lrck_fall", n_bad_chg, 0);
        check("t2_chg_at_sclk_fall", n_fall_chg, 0);

        // Test 3: one frame without a pair.
        clr_stats();
        run(256);
        check("t3_underrun_at_fs", underrun, 1);
        check("t3_data_l", data_L_out, MUTE ? 24'h0 : 24'h000103);
        check("t3_data_r", data_R_out, MUTE ? 24'h0 : 24'h00F003);
        tick();
        check("t3_underrun_off", underrun, 0);
        check("t3_underrun_cycles", n_underrun, 1);
        check("t3_underrun_pulses", n_ur_rise, 1);

        // Test 4: valid held high continuously.
        sample_L_in = 24'h0A0A0A; sample_R_in = 24'h050505; sample_valid = 1'b1;
        clr_stats();
        tick();
        check("t4_ready_after_accept", sample_ready, 0);
        run(253);
        check("t4_ready_before_fs", sample_ready, 0);
        check("t4_one_xfer", n_xfer, 1);
        tick();
        check("t4_ready_at_fs", sample_ready, 1);
        check("t4_data_l", data_L_out, 24'h0A0A0A);
        check("t4_underrun", underrun, 0);
        clr_stats();
        run(256);
        check("t4_xfer_per_frame", n_xfer, 1);
        check("t4_no_underrun", n_underrun, 0);

        // Test 5: reset at CLK 100 of a frame with a pending pair.
        run(100);
        check("t5_pending", sample_ready, 0);
        RST = 1'b1;
        #1;
        check("t5_sclk", SCLK, 0);
        check("t5_lrck", LRCK, 0);
        check("t5_data_l", data_L_out, 0);
        check("t5_data_r", data_R_out, 0);
        check("t5_underrun", underrun, 0);
        check("t5_ready", sample_ready, 1);

        // Test 6: EN dropped mid right slot for 20 CLK.
        @(negedge CLK);
        RST = 1'b0; sample_valid = 1'b0; EN = 1'b1;
        snap(); clr_stats();
        tick();
        check("t6_restart_underrun", underrun, 1);
        sample_L_in = 24'h654321; sample_R_in = 24'h0FEDCB; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        run(252);
        check("t6_data_l", data_L_out, 24'h654321);
        run(192);
        check("t6_right_slot", LRCK, 1);
        EN = 1'b0;
        sample_L_in = 24'h111111; sample_R_in = 24'h222222; sample_valid = 1'b1;
        clr_stats();
        tick();
        check("t6_stop_sclk", SCLK, 0);
        check("t6_stop_lrck", LRCK, 0);
        check("t6_stop_handshake", sample_ready, 0);
        sample_valid = 1'b0;
        run(19);
        check("t6_stop_sclk_hi", n_sclk_hi, 0);
        check("t6_stop_lrck_hi", n_lrck_hi, 0);
        check("t6_stop_dchg", n_dchg, 0);
        check("t6_stop_data_r", data_R_out, 24'h0FEDCB);
        EN = 1'b1;
        tick();
        check("t6_fs_data_l", data_L_out, 24'h111111);
        check("t6_fs_data_r", data_R_out, 24'h222222);
        check("t6_fs_underrun", underrun, 0);
        check("t6_fs_ready", sample_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
